// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - three-phase complementary gate drive with dead-time insertion and fault trip
`timescale 1ns/1ps
module pwm_deadtime #(
    parameter int DT_W   = 8,
    parameter int DT_MIN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_a,
    input  logic            pwm_b,
    input  logic            pwm_c,
    input  logic [DT_W-1:0] dt_cfg,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            outUA_P,
    output logic            outUA_N,
    output logic            outUB_P,
    output logic            outUB_N,
    output logic            outUC_P,
    output logic            outUC_N,
    output logic            fault_lat,
    output logic [2:0]      busy
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DT_P = 3'd1,
        S_P_ON = 3'd2,
        S_DT_N = 3'd3,
        S_N_ON = 3'd4
    } state_t;

    localparam logic [DT_W-1:0] DT_MIN_W = DT_W'(DT_MIN);
    localparam logic [DT_W-1:0] CNT_ONE  = DT_W'(1);

    state_t          state_q [3];
    state_t          state_d [3];
    logic [DT_W-1:0] cnt_q   [3];
    logic [DT_W-1:0] cnt_d   [3];
    logic [2:0]      drv_p;
    logic [2:0]      drv_n;
    logic [2:0]      pwm;
    logic [DT_W-1:0] dt_eff;
    logic            fault_lat_d;

    assign pwm    = {pwm_c, pwm_b, pwm_a};
    assign dt_eff = (dt_cfg < DT_MIN_W) ? DT_MIN_W : dt_cfg;

    // A simultaneous trip and clear keeps the latch set.
    always_comb begin
        fault_lat_d = fault_lat;
        if (fault) begin
            fault_lat_d = 1'b1;
        end else if (fault_clr) begin
            fault_lat_d = 1'b0;
        end
    end

    // Priority per phase: fault, then enable, then command/count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (fault || !en) begin
                state_d[i] = S_OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    S_OFF: begin
                        if (!fault_lat) begin
                            state_d[i] = pwm[i] ? S_DT_P : S_DT_N;
                            cnt_d[i]   = dt_eff;
                        end
                    end
                    S_DT_P: begin
                        if (!pwm[i]) begin
                            state_d[i] = S_DT_N;
                            cnt_d[i]   = dt_eff;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            state_d[i] = S_P_ON;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    S_P_ON: begin
                        if (!pwm[i]) begin
                            state_d[i] = S_DT_N;
                            cnt_d[i]   = dt_eff;
                        end
                    end
                    S_DT_N: begin
                        if (pwm[i]) begin
                            state_d[i] = S_DT_P;
                            cnt_d[i]   = dt_eff;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            state_d[i] = S_N_ON;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    S_N_ON: begin
                        if (pwm[i]) begin
                            state_d[i] = S_DT_P;
                            cnt_d[i]   = dt_eff;
                        end
                    end
                    default: begin
                        state_d[i] = S_OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Drives and busy are decoded from the next state so they switch with the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= S_OFF;
                cnt_q[i]   <= '0;
            end
            drv_p     <= '0;
            drv_n     <= '0;
            busy      <= '0;
            fault_lat <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                drv_p[i]   <= (state_d[i] == S_P_ON);
                drv_n[i]   <= (state_d[i] == S_N_ON);
                busy[i]    <= (state_d[i] == S_DT_P) || (state_d[i] == S_DT_N);
            end
            fault_lat <= fault_lat_d;
        end
    end

    assign outUA_P = drv_p[0];
    assign outUA_N = drv_n[0];
    assign outUB_P = drv_p[1];
    assign outUB_N = drv_n[1];
    assign outUC_P = drv_p[2];
    assign outUC_N = drv_n[2];

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - scoreboard bench for pwm_deadtime
`timescale 1ns/1ps
module tb_pwm_deadtime;

    localparam int DT_W   = 8;
    localparam int DT_MIN = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic            pwm_a, pwm_b, pwm_c;
    logic [DT_W-1:0] dt_cfg;
    logic            fault, fault_clr;
    logic            outUA_P, outUA_N, outUB_P, outUB_N, outUC_P, outUC_N;
    logic            fault_lat;
    logic [2:0]      busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q [$];
    logic [9:0] exp_v, obs_v;

    pwm_deadtime #(.DT_W(DT_W), .DT_MIN(DT_MIN)) dut (
        .clk(clk), .rst(rst), .en(en),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .pwm_c(pwm_c),
        .dt_cfg(dt_cfg), .fault(fault), .fault_clr(fault_clr),
        .outUA_P(outUA_P), .outUA_N(outUA_N),
        .outUB_P(outUB_P), .outUB_N(outUB_N),
        .outUC_P(outUC_P), .outUC_N(outUC_N),
        .fault_lat(fault_lat), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] obs_vec();
        return {fault_lat, busy, outUA_P, outUA_N, outUB_P, outUB_N, outUC_P, outUC_N};
    endfunction

    function automatic logic [9:0] mk(input logic flt, input logic [2:0] bsy,
                                      input logic ap, input logic an, input logic bp,
                                      input logic bn, input logic cp, input logic cn);
        return {flt, bsy, ap, an, bp, bn, cp, cn};
    endfunction

    function automatic int eff_dt(input logic [DT_W-1:0] c);
        return (int'(c) < DT_MIN) ? DT_MIN : int'(c);
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0; pwm_c = 1'b0;
        dt_cfg = '0; fault = 1'b0; fault_clr = 1'b0;
        exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0));
        #2;
        exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_async obs=%b exp=%b", obs_v, exp_v); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL reset_idle t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_startup();
        dt_cfg = 8'd5; pwm_a = 1'b1; pwm_b = 1'b0; pwm_c = 1'b0; en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            exp_q.push_back(mk(0, (t < 5) ? 3'b111 : 3'b000, t >= 5, 0, 0, t >= 5, 0, t >= 5));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL startup t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_transition();
        for (int t = 0; t < 14; t++) begin
            if (t == 0) begin dt_cfg = 8'd10; pwm_a = 1'b0; end
            if (t == 3) dt_cfg = 8'd3;
            exp_q.push_back(mk(0, {2'b00, t < 10}, 0, t >= 10, 0, 1, 0, 1));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL transition t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_min_clamp();
        dt_cfg = 8'd0; pwm_a = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_q.push_back(mk(0, {2'b00, t < 2}, t >= 2, 0, 0, 1, 0, 1));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL min_clamp t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_reversal();
        logic bp, bb;
        dt_cfg = 8'd8;
        for (int t = 0; t < 24; t++) begin
            pwm_b = (t == 10 || t == 11) ? 1'b0 : 1'b1;
            bp = ((t >= 8) && (t < 10)) || (t >= 20);
            bb = (t < 8) || ((t >= 10) && (t < 20));
            exp_q.push_back(mk(0, {1'b0, bb, 1'b0}, 1, 0, bp, 0, 0, 1));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL reversal t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_fault();
        logic [9:0] e;
        dt_cfg = 8'd6; pwm_c = 1'b1;
        for (int t = 0; t < 16; t++) begin
            fault     = (t == 2 || t == 4);
            fault_clr = (t == 4 || t == 6);
            if (t < 2)       e = mk(0, 3'b100, 1, 0, 1, 0, 0, 0);
            else if (t < 6)  e = mk(1, 3'b000, 0, 0, 0, 0, 0, 0);
            else if (t == 6) e = mk(0, 3'b000, 0, 0, 0, 0, 0, 0);
            else if (t < 13) e = mk(0, 3'b111, 0, 0, 0, 0, 0, 0);
            else             e = mk(0, 3'b000, 1, 0, 1, 0, 1, 0);
            exp_q.push_back(e);
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL fault t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
        fault = 1'b0; fault_clr = 1'b0;
    endtask

    task automatic test_enable();
        dt_cfg = 8'd3;
        for (int t = 0; t < 7; t++) begin
            en = (t != 0);
            pwm_a = 1'b0;
            exp_q.push_back(mk(0, (t >= 1 && t < 4) ? 3'b111 : 3'b000,
                               0, t >= 4, t >= 4, 0, t >= 4, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL enable t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        n_tests++;
        if (outUA_N !== 1'b1) begin n_fail++; $display("FAIL areset_pre obs=%b exp=1", outUA_N); end
        #2 rst = 1'b1;
        exp_q.push_back(mk(0, 3'b000, 0, 0, 0, 0, 0, 0));
        #1;
        exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
        if (obs_v !== exp_v) begin n_fail++; $display("FAIL areset_async obs=%b exp=%b", obs_v, exp_v); end
        @(posedge clk); #1;
        #2 rst = 1'b0;
        dt_cfg = 8'd3; pwm_a = 1'b1; pwm_b = 1'b0; pwm_c = 1'b1;
        for (int t = 0; t < 5; t++) begin
            exp_q.push_back(mk(0, (t < 3) ? 3'b111 : 3'b000, t >= 3, 0, 0, t >= 3, t >= 3, 0));
            @(posedge clk); #1;
            exp_v = exp_q.pop_front(); obs_v = obs_vec(); n_tests++;
            if (obs_v !== exp_v) begin n_fail++; $display("FAIL areset_restart t=%0d obs=%b exp=%b", t, obs_v, exp_v); end
        end
    endtask

    task automatic test_random();
        int         eff_hist [256];
        int         off_run  [3];
        logic [1:0] prev     [3];
        logic [1:0] cur      [3];
        logic       ok;
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 256; i++) eff_hist[i] = 0;
        for (int p = 0; p < 3; p++) begin off_run[p] = 0; prev[p] = 2'b00; end
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(0, 7) == 0) pwm_a = ~pwm_a;
            if ($urandom_range(0, 7) == 0) pwm_b = ~pwm_b;
            if ($urandom_range(0, 7) == 0) pwm_c = ~pwm_c;
            if ($urandom_range(0, 15) == 0) dt_cfg = DT_W'($urandom_range(0, 12));
            en        = ($urandom_range(0, 63) != 0);
            fault     = ($urandom_range(0, 255) == 0);
            fault_clr = ($urandom_range(0, 15) == 0);
            eff_hist[k % 256] = eff_dt(dt_cfg);
            @(posedge clk); #1;
            cur[0] = {outUA_P, outUA_N};
            cur[1] = {outUB_P, outUB_N};
            cur[2] = {outUC_P, outUC_N};
            for (int p = 0; p < 3; p++) begin
                n_tests++;
                if (cur[p] === 2'b11) begin
                    n_fail++; $display("FAIL random_overlap k=%0d phase=%0d obs=%b exp=not 11", k, p, cur[p]);
                end
                if ((cur[p][1] && !prev[p][1]) || (cur[p][0] && !prev[p][0])) begin
                    ok = 1'b0;
                    for (int d = 1; d <= off_run[p] && d <= 255; d++)
                        if (eff_hist[(k - d) & 255] == d) ok = 1'b1;
                    n_tests++;
                    if (!ok) begin
                        n_fail++; $display("FAIL random_deadtime k=%0d phase=%0d off_cycles=%0d exp=matching DT", k, p, off_run[p]);
                    end
                end
                off_run[p] = (cur[p] == 2'b00) ? off_run[p] + 1 : 0;
                prev[p] = cur[p];
            end
        end
        fault = 1'b0; fault_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_transition();
        test_min_clamp();
        test_reversal();
        test_fault();
        test_enable();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
